zstd_frame_sequencer: RTL and testbench

Frame-level controller for the Zstandard decompressor. It owns the 16-bit compressed input stream and sequences each frame through three steps: header parsing, a loop over Block_Header → block-decoder dispatch, and the optional Content_Checksum. It sits above the frame-header parser and the block decoders, and tracks byte alignment across ownership changes with a one-byte spare register.

---
 rtl/zstd_frame_sequencer.sv | 152 +++++++++++++++
 tb/tb_zstd_frame_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/zstd_frame_sequencer.sv
// zstd_frame_sequencer: sequences a zstd frame through header, block dispatch loop and optional checksum
module zstd_frame_sequencer #(
  parameter int MAX_BLOCK_SIZE = 131072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [1:0]  stream_owner,
  output logic        hdr_start,
  input  logic        hdr_finished,
  input  logic        hdr_checksum_flag,
  input  logic        hdr_spare_valid,
  input  logic [7:0]  hdr_spare_byte,
  output logic        blk_start,
  output logic [1:0]  blk_type,
  output logic [20:0] blk_size,
  output logic        blk_last,
  output logic        blk_spare_valid,
  output logic [7:0]  blk_spare_byte,
  input  logic        blk_done,
  input  logic        done_spare_valid,
  input  logic [7:0]  done_spare_byte,
  output logic        chk_valid,
  output logic [31:0] chk_value,
  output logic        frame_done,
  output logic        err,
  output logic [1:0]  err_code
);
  typedef enum logic [3:0] {
    IDLE, HDR_START, HDR_WAIT, BH_READ, BH_CHECK, BLK_START, BLK_WAIT, CHK_READ, DONE, ERROR
  } state_t;
  state_t state;
  logic spare_v, chk_flag, accept, full, extra;
  logic [7:0] spare_b;
  logic [2:0] n, need;
  logic [39:0] col, col_nx;
  assign blk_spare_valid = spare_v;
  assign blk_spare_byte = spare_b;
  assign accept = in_ready && in_valid;
  assign need = state == CHK_READ ? 3'd4 : 3'd3;
  assign full = n + 3'd2 >= need;
  assign extra = n + 3'd2 > need;
  // collector is little-endian by byte index; n counts bytes already held (seeded with the spare)
  assign col_nx = col | ({24'b0, in_data[7:0], in_data[15:8]} << {n, 3'b000});
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      in_ready <= 1'b0;
      stream_owner <= 2'd0;
      hdr_start <= 1'b0;
      blk_start <= 1'b0;
      blk_type <= 2'd0;
      blk_size <= 21'd0;
      blk_last <= 1'b0;
      chk_valid <= 1'b0;
      chk_value <= 32'd0;
      frame_done <= 1'b0;
      err <= 1'b0;
      err_code <= 2'd0;
      spare_v <= 1'b0;
      spare_b <= 8'd0;
      chk_flag <= 1'b0;
      n <= 3'd0;
      col <= 40'd0;
    end else begin
      hdr_start <= 1'b0;
      blk_start <= 1'b0;
      chk_valid <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE, ERROR: if (frame_start) begin
          state <= HDR_START;
          hdr_start <= 1'b1;
          stream_owner <= 2'd1;
          spare_v <= 1'b0;
          spare_b <= 8'd0;
          err <= 1'b0;
          err_code <= 2'd0;
        end
        HDR_START: state <= HDR_WAIT;
        HDR_WAIT: if (hdr_finished) begin
          chk_flag <= hdr_checksum_flag;
          spare_v <= hdr_spare_valid;
          spare_b <= hdr_spare_byte;
          n <= {2'b0, hdr_spare_valid};
          col <= {32'b0, hdr_spare_valid ? hdr_spare_byte : 8'h00};
          stream_owner <= 2'd0;
          in_ready <= 1'b1;
          state <= BH_READ;
        end
        BH_READ, CHK_READ: if (accept) begin
          col <= col_nx;
          n <= n + 3'd2;
          if (full) begin
            in_ready <= 1'b0;
            spare_v <= extra;
            spare_b <= in_data[7:0];
            state <= state == BH_READ ? BH_CHECK : DONE;
            chk_valid <= state == CHK_READ;
            frame_done <= state == CHK_READ;
            if (state == CHK_READ) chk_value <= col_nx[31:0];
          end
        end
        BH_CHECK: begin
          blk_last <= col[0];
          blk_type <= col[2:1];
          blk_size <= col[23:3];
          if (col[2:1] == 2'd3) begin
            state <= ERROR;
            err <= 1'b1;
            err_code <= 2'd1;
          end else if (col[23:3] > 21'(MAX_BLOCK_SIZE)) begin
            state <= ERROR;
            err <= 1'b1;
            err_code <= 2'd2;
          end else begin
            state <= BLK_START;
            blk_start <= 1'b1;
            stream_owner <= 2'd2;
          end
        end
        BLK_START: state <= BLK_WAIT;
        BLK_WAIT: if (blk_done) begin
          spare_v <= done_spare_valid;
          spare_b <= done_spare_byte;
          n <= {2'b0, done_spare_valid};
          col <= {32'b0, done_spare_valid ? done_spare_byte : 8'h00};
          stream_owner <= 2'd0;
          if (!blk_last) begin
            state <= BH_READ;
            in_ready <= 1'b1;
          end else if (chk_flag) begin
            state <= CHK_READ;
            in_ready <= 1'b1;
          end else begin
            state <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          spare_v <= 1'b0;
          spare_b <= 8'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_zstd_frame_sequencer.sv
// tb_zstd_frame_sequencer: randomized scoreboard bench with a byte-stream reference model
module tb_zstd_frame_sequencer;
  logic clk = 0, reset = 1;
  logic frame_start = 0, in_valid = 0, hdr_finished = 0, hdr_checksum_flag = 0, hdr_spare_valid = 0;
  logic blk_done = 0, done_spare_valid = 0;
  logic [15:0] in_data = 0;
  logic [7:0] hdr_spare_byte = 0, done_spare_byte = 0;
  logic in_ready, hdr_start, blk_start, blk_last, blk_spare_valid, chk_valid, frame_done, err;
  logic [1:0] stream_owner, blk_type, err_code;
  logic [20:0] blk_size;
  logic [7:0] blk_spare_byte;
  logic [31:0] chk_value;
  logic [74:0] outs;
  zstd_frame_sequencer dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .stream_owner(stream_owner), .hdr_start(hdr_start),
    .hdr_finished(hdr_finished), .hdr_checksum_flag(hdr_checksum_flag),
    .hdr_spare_valid(hdr_spare_valid), .hdr_spare_byte(hdr_spare_byte), .blk_start(blk_start),
    .blk_type(blk_type), .blk_size(blk_size), .blk_last(blk_last),
    .blk_spare_valid(blk_spare_valid), .blk_spare_byte(blk_spare_byte), .blk_done(blk_done),
    .done_spare_valid(done_spare_valid), .done_spare_byte(done_spare_byte),
    .chk_valid(chk_valid), .chk_value(chk_value), .frame_done(frame_done), .err(err),
    .err_code(err_code)
  );
  assign outs = {in_ready, stream_owner, hdr_start, blk_start, blk_type, blk_size, blk_last,
                 blk_spare_valid, blk_spare_byte, chk_valid, chk_value, frame_done, err, err_code};
  always #5 clk = ~clk;
  typedef struct { logic [3:0] kind; logic [63:0] v; } ev_t;
  ev_t sb[$];
  logic [15:0] wq[$];
  logic [23:0] hq[$];
  int compared = 0, mismatched = 0, fsv = -1;
  bit no_stall = 0, m_sv = 0, err_q = 0;
  logic [7:0] m_sb = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic expect_ev(input logic [3:0] k, input logic [63:0] v);
    ev_t e;
    e.kind = k;
    e.v = v;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input string name, input logic [3:0] k, input logic [63:0] v);
    ev_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s: got unexpected output %0h, expected nothing", name, v);
    end else begin
      e = sb.pop_front();
      chk(name, {k, v}, {e.kind, e.v});
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a result
  always @(negedge clk) begin
    if (!reset) begin
      if (in_ready) chk("ready_owner", stream_owner, 0);
      if (blk_start)
        pop_cmp("blk", 0, 64'({blk_type, blk_last, blk_spare_valid,
                               blk_spare_valid ? blk_spare_byte : 8'h00, blk_size}));
      if (chk_valid) pop_cmp("chk", 1, 64'(chk_value));
      if (frame_done) pop_cmp("frame_done", 2, 0);
      if (err && !err_q) pop_cmp("err", 3, 64'(err_code));
    end
    err_q = err;
  end

  // reference stream: the previous owner may hold the first needed byte as its spare; words
  // carry the rest, and an odd leftover byte of the final word becomes the next spare
  task automatic prep(input logic [31:0] d, input int need, output bit sv, output logic [7:0] sb_o);
    logic [7:0] q[$];
    logic [7:0] a;
    for (int i = 0; i < need; i++) q.push_back(d[8*i +: 8]);
    sv = (fsv < 0) ? 1'($urandom_range(0, 1)) : 1'(fsv);
    sb_o = sv ? q.pop_front() : 8'($urandom);
    m_sv = q.size() % 2 == 1;
    if (m_sv) begin
      m_sb = 8'($urandom);
      q.push_back(m_sb);
    end
    while (q.size() > 0) begin
      a = q.pop_front();
      wq.push_back({a, q.pop_front()});
    end
  endtask

  task automatic feed();
    int g = 0;
    bit acc;
    while (wq.size() > 0 && g < 500) begin
      @(negedge clk);
      in_valid = no_stall || $urandom_range(0, 1) == 1;
      in_data = wq[0];
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) void'(wq.pop_front());
      g++;
    end
    @(negedge clk);
    in_valid = 0;
    if (wq.size() > 0) begin
      chk("feed_timeout", wq.size(), 0);
      wq.delete();
    end
    chk("ready_drop", in_ready, 0);
  endtask

  function automatic logic [23:0] rand_hdr(input bit last);
    int r = $urandom_range(0, 11);
    logic [20:0] size = r == 1 ? 21'(131073 + $urandom_range(0, 5000)) : r == 2 ? 21'd131072 :
                        r == 3 ? 21'($urandom) : 21'($urandom_range(0, 400));
    logic [1:0] t = r == 0 ? 2'd3 : 2'($urandom_range(0, 2));
    return {size, t, last};
  endfunction

  task automatic run_frame(input int nb, input bit ck, input logic [31:0] cv, input bit rst_mid);
    logic [23:0] h[4];
    bit sv, bad;
    logic [7:0] sbyte;
    for (int i = 0; i < nb; i++) h[i] = hq.size() > 0 ? hq.pop_front() : rand_hdr(i == nb - 1);
    @(negedge clk);
    frame_start = 1;
    @(negedge clk);
    frame_start = 0;
    chk("frame_start", {hdr_start, stream_owner, err, err_code}, {1'b1, 2'd1, 1'b0, 2'd0});
    repeat ($urandom_range(1, 3)) @(negedge clk);
    prep({8'h00, h[0]}, 3, sv, sbyte);
    hdr_finished = 1;
    hdr_checksum_flag = ck;
    hdr_spare_valid = sv;
    hdr_spare_byte = sbyte;
    @(negedge clk);
    hdr_finished = 0;
    chk("hdr_to_read", {in_ready, stream_owner}, {1'b1, 2'd0});
    for (int i = 0; i < nb; i++) begin
      bad = h[i][2:1] == 2'd3 || h[i][23:3] > 21'd131072;
      if (h[i][2:1] == 2'd3) expect_ev(3, 1);
      else if (bad) expect_ev(3, 2);
      else expect_ev(0, 64'({h[i][2:1], h[i][0], m_sv, m_sv ? m_sb : 8'h00, h[i][23:3]}));
      feed();
      if (bad) begin
        repeat (3) @(negedge clk);
        chk("err_hold", {in_ready, stream_owner, err}, {1'b0, 2'd0, 1'b1});
        return;
      end
      @(negedge clk);
      chk("blk_latency", {blk_start, stream_owner}, {1'b1, 2'd2});
      if (rst_mid) begin
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        sb.delete();
        chk("reset_outs", outs, 0);
        blk_done = 1;
        @(negedge clk);
        blk_done = 0;
        chk("post_reset_blk_done", {in_ready, stream_owner, frame_done, blk_start}, 0);
        return;
      end
      repeat ($urandom_range(1, 4)) @(negedge clk);
      if (!h[i][0]) prep({8'h00, h[i+1]}, 3, sv, sbyte);
      else if (ck) begin
        prep(cv, 4, sv, sbyte);
        expect_ev(1, 64'(cv));
        expect_ev(2, 0);
      end else begin
        sv = 1'($urandom_range(0, 1));
        sbyte = 8'($urandom);
        expect_ev(2, 0);
      end
      blk_done = 1;
      done_spare_valid = sv;
      done_spare_byte = sbyte;
      @(negedge clk);
      blk_done = 0;
      if (!h[i][0] || ck) chk("done_to_read", in_ready, 1);
      else chk("done_to_frame_done", frame_done, 1);
      if (h[i][0] && ck) feed();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_state", outs, 0);
    reset = 0;
    no_stall = 1;
    fsv = 1;
    hq.push_back(24'h000029);
    run_frame(1, 0, 0, 0);
    fsv = 0;
    hq.push_back(24'h000029);
    run_frame(1, 0, 0, 0);
    hq.push_back(24'h000010);
    hq.push_back(24'h00000B);
    run_frame(2, 1, 32'h12345678, 0);
    hq.push_back(24'h000007);
    run_frame(1, 0, 0, 0);
    hq.push_back({21'd131073, 2'd0, 1'b1});
    run_frame(1, 0, 0, 0);
    hq.push_back({21'd131072, 2'd0, 1'b1});
    run_frame(1, 0, 0, 0);
    fsv = -1;
    no_stall = 0;
    hq.push_back(24'h000028);
    run_frame(1, 0, 0, 1);
    for (int k = 0; k < 60; k++)
      run_frame($urandom_range(1, 3), 1'($urandom_range(0, 1)), $urandom, 0);
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
